alu_frame_tx: RTL and testbench

ALU_FRAME_TX -- requirements
Module: alu_frame_tx

---
 rtl/alu_frame_pkg.sv | 28 ++
 rtl/alu_frame_shreg.sv | 37 +++
 rtl/alu_frame_tx.sv | 111 +++++++++++
 tb/tb_alu_frame_tx.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu_frame_pkg.sv
// Shared constants for the ALU frame transmitter: opcodes, FSM states, frame sizing.
package alu_frame_pkg;

  localparam int unsigned FRAME_BITS   = 10;
  localparam int unsigned PAYLOAD_BITS = 10;

  typedef enum logic [1:0] {
    OP_DIV = 2'b00,
    OP_SUB = 2'b01,
    OP_SUM = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RST  = 2'b01,
    ST_SEND = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  // Transmission order is op[1] first, b[0] last.
  function automatic logic [PAYLOAD_BITS-1:0] pack_frame(input logic [1:0] op,
                                                         input logic [3:0] a,
                                                         input logic [3:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/alu_frame_shreg.sv
// Parallel-load, MSB-first shift register holding the frame in flight.
module alu_frame_shreg
  import alu_frame_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb = sh_q[WIDTH-1];

endmodule

// File: rtl/alu_frame_tx.sv
// Serialises {op,a,b} to a downstream serial ALU: reset pulse, frame bits, done pulse.
//   state | meaning
//   IDLE  | waiting for start; frame latched on the accepting edge
//   RST   | one-cycle alu_reset pulse
//   SEND  | one frame bit per cycle, MSB first
//   FIN   | one-cycle done pulse, then back to IDLE
module alu_frame_tx
  import alu_frame_pkg::*;
#(
  parameter int unsigned FRAME_BITS = alu_frame_pkg::FRAME_BITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       alu_reset,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] CNT_LAST = 4'(FRAME_BITS - 1);

  state_e                state_q;
  logic [3:0]            bit_cnt_q;
  logic                  alu_reset_q;
  logic                  data_out_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  sh_load;
  logic                  sh_shift;
  logic                  sh_msb;
  logic [FRAME_BITS-1:0] load_word;

  // Payload is left-justified so the opcode always leads the frame.
  always_comb begin
    load_word = '0;
    load_word[FRAME_BITS-1 -: PAYLOAD_BITS] = pack_frame(op, a, b);
  end

  assign sh_load  = (state_q == ST_IDLE) && start;
  assign sh_shift = (state_q == ST_RST) ||
                    ((state_q == ST_SEND) && (bit_cnt_q != CNT_LAST));

  alu_frame_shreg #(
    .WIDTH (FRAME_BITS)
  ) u_shreg (
    .clock (clock),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (load_word),
    .msb   (sh_msb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      alu_reset_q <= 1'b0;
      data_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      alu_reset_q <= 1'b0;
      data_out_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_RST;
            alu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_RST: begin
          state_q    <= ST_SEND;
          bit_cnt_q  <= '0;
          data_out_q <= sh_msb;
        end
        ST_SEND: begin
          if (bit_cnt_q == CNT_LAST) begin
            state_q   <= ST_FIN;
            bit_cnt_q <= '0;
            done_q    <= 1'b1;
          end else begin
            bit_cnt_q  <= bit_cnt_q + 4'd1;
            data_out_q <= sh_msb;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_reset = alu_reset_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_frame_tx.sv
// Directed bench for alu_frame_tx with hand-computed frame patterns.
module tb_alu_frame_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       alu_reset;
  logic       data_out;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  alu_frame_tx dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .alu_reset (alu_reset),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ar, input logic d, input logic bz, input logic dn);
    chk({tag, ".alu_reset"}, {15'd0, alu_reset}, {15'd0, ar});
    chk({tag, ".data_out"},  {15'd0, data_out},  {15'd0, d});
    chk({tag, ".busy"},      {15'd0, busy},      {15'd0, bz});
    chk({tag, ".done"},      {15'd0, done},      {15'd0, dn});
  endtask

  // mode: 0 plain, 1 clear a in SEND cycle 3, 2 hold start, 3 pulse start mid-SEND
  task automatic run_frame(input string tag, input logic [1:0] op_v, input logic [3:0] a_v,
                           input logic [3:0] b_v, input logic [9:0] exp, input int mode);
    op = op_v; a = a_v; b = b_v; start = 1'b1;
    tick();
    chk_outs({tag, ".rst"}, 1'b1, 1'b0, 1'b1, 1'b0);
    if (mode != 2) start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_outs($sformatf("%s.bit%0d", tag, i), 1'b0, exp[9-i], 1'b1, 1'b0);
      if (mode == 1 && i == 2) a = 4'b0000;
      if (mode == 3 && i == 4) start = 1'b1;
      if (mode == 3 && i == 5) start = 1'b0;
    end
    tick();
    chk_outs({tag, ".fin"}, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 4'd0; b = 4'd0;
    #1;
    chk_outs("por", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_outs("por_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_outs("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    run_frame("sum", 2'b10, 4'b0011, 4'b0001, 10'b1000110001, 0);
    run_frame("mul", 2'b11, 4'b0101, 4'b0010, 10'b1101010010, 0);
    run_frame("sub", 2'b01, 4'b1101, 4'b0100, 10'b0111010100, 1);

    // Held start: two DIV frames separated by one IDLE cycle.
    run_frame("div_a", 2'b00, 4'b1001, 4'b0000, 10'b0010010000, 2);
    run_frame("div_b", 2'b00, 4'b1001, 4'b0000, 10'b0010010000, 0);
    tick();
    chk_outs("div_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // start pulse inside SEND must not retrigger.
    run_frame("ign", 2'b10, 4'b0011, 4'b0001, 10'b1000110001, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("ign.quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Abort at SEND bit 5 (a[0]=1 for this SUM frame).
    op = 2'b10; a = 4'b0011; b = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_outs("abort.bit5", 1'b0, 1'b1, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1 chk_outs("abort.async", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_outs("abort.hold", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    run_frame("div3", 2'b00, 4'b1001, 4'b0011, 10'b0010010011, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
